// File: rtl/key_debounce.sv
// Purpose: per-key 2-FF synchroniser plus debounce FSM giving clean level and press/release pulses.
// Latency: a clean edge on key_in sampled at edge E shows on the outputs after edge E+DB_CYCLES+1.
// Backpressure: none; free-running conditioning stage, outputs are valid every cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   key_in       raw asynchronous key/switch inputs (polarity set by KEY_ACT_LOW)
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse when a press is accepted
//   key_release  1-cycle pulse when a release is accepted
module key_debounce #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 250000,
  parameter int CNT_W       = 18,
  parameter bit KEY_ACT_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  // Raw level of a key that is not pressed; synchroniser resets to it so
  // that reset deassertion alone never looks like an edge.
  localparam logic [N_KEYS-1:0] INACTIVE = {N_KEYS{KEY_ACT_LOW}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    CONF_PRESS = 2'd1,
    PRESSED    = 2'd2,
    CONF_REL   = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalised polarity: 1 = pressed from here on.
  assign act = sync2_q ^ INACTIVE;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next state. The counter holds the number of consecutive cycles the
    // new level has been seen; any bounce drops back to the stable state.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        RELEASED: begin
          if (act[g]) begin
            state_d = CONF_PRESS;
            cnt_d   = CNT_W'(1);
          end
        end
        CONF_PRESS: begin
          if (!act[g]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!act[g]) begin
            state_d = CONF_REL;
            cnt_d   = CNT_W'(1);
          end
        end
        CONF_REL: begin
          if (act[g]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs decoded from the transition being taken, so they appear in
    // the same cycle as the new state.
    always_comb begin
      level_d   = (state_d == PRESSED) || (state_d == CONF_REL);
      press_d   = (state_q == CONF_PRESS) && (state_d == PRESSED);
      release_d = (state_q == CONF_REL) && (state_d == RELEASED);
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  int checks;
  int errors;
  int press_cnt [N];
  int rel_cnt   [N];

  key_debounce #(
    .N_KEYS     (N),
    .DB_CYCLES  (DB),
    .CNT_W      (3),
    .KEY_ACT_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the pressed/released level flips once the (two-cycle
  // delayed) input has disagreed with it for DB consecutive cycles.
  logic [N-1:0] d1, d2;
  logic [N-1:0] m_level, m_press, m_rel;
  int unsigned  run [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1      <= '0;
      d2      <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int k = 0; k < N; k++) run[k] <= 0;
    end else begin
      d1 <= ~key_in;
      d2 <= d1;
      for (int k = 0; k < N; k++) begin
        m_press[k] <= 1'b0;
        m_rel[k]   <= 1'b0;
        if (d2[k] != m_level[k]) begin
          if (run[k] + 1 == DB) begin
            m_level[k] <= d2[k];
            m_press[k] <= d2[k];
            m_rel[k]   <= ~d2[k];
            run[k]     <= 0;
          end else begin
            run[k] <= run[k] + 1;
          end
        end else begin
          run[k] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse counting.
  always @(negedge clk) begin
    check("level", int'(key_level), int'(m_level));
    check("press", int'(key_press), int'(m_press));
    check("release", int'(key_release), int'(m_rel));
    for (int k = 0; k < N; k++) begin
      press_cnt[k] += int'(key_press[k]);
      rel_cnt[k]   += int'(key_release[k]);
    end
  end

  // Call right after driving at a negedge: the pulse must be absent for
  // five edges, present after the sixth, and gone after the seventh.
  task automatic wait_pulse(input string nm, input logic [N-1:0] mask, input bit is_press);
    logic [N-1:0] p;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      p = is_press ? key_press : key_release;
      check({nm, "_early"}, int'(p & mask), 0);
    end
    @(posedge clk); #1;
    p = is_press ? key_press : key_release;
    check(nm, int'(p & mask), int'(mask));
    check({nm, "_model"}, int'((is_press ? m_press : m_rel) & mask), int'(mask));
    check({nm, "_lvl"}, int'(key_level & mask), is_press ? int'(mask) : 0);
    @(posedge clk); #1;
    p = is_press ? key_press : key_release;
    check({nm, "_1cyc"}, int'(p & mask), 0);
  endtask

  int snap_p, snap_r, tot;
  int hold [N];

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < N; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      hold[k]      = 0;
    end
    reset  = 1'b0;
    key_in = '1;

    // 1. reset held, then idle after release
    repeat (3) @(negedge clk);
    #1;
    check("rst_level", int'(key_level), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_release", int'(key_release), 0);
    @(negedge clk);
    reset = 1'b1;
    tot = 0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < N; k++) tot += press_cnt[k] + rel_cnt[k];
    check("idle_pulses", tot, 0);

    // 2. clean press and release on key 0
    key_in[0] = 1'b0;
    wait_pulse("t2_press", 4'b0001, 1'b1);
    @(negedge clk);
    key_in[0] = 1'b1;
    wait_pulse("t2_release", 4'b0001, 1'b0);
    repeat (5) @(negedge clk);

    // 3. bouncing key 1, one press after settling
    snap_p = press_cnt[1];
    snap_r = rel_cnt[1];
    for (int b = 0; b < 4; b++) begin
      key_in[1] = b[0];
      repeat (2) @(negedge clk);
    end
    key_in[1] = 1'b0;
    wait_pulse("t3_press", 4'b0010, 1'b1);
    repeat (5) @(negedge clk);
    check("t3_one_press", press_cnt[1] - snap_p, 1);
    check("t3_no_release", rel_cnt[1] - snap_r, 0);
    key_in[1] = 1'b1;
    repeat (12) @(negedge clk);

    // 4. short low on key 2 is rejected
    snap_p = press_cnt[2];
    key_in[2] = 1'b0;
    repeat (3) @(negedge clk);
    key_in[2] = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_no_press", press_cnt[2] - snap_p, 0);
    check("t4_level", int'(key_level[2]), 0);

    // 5. all keys together
    key_in = '0;
    wait_pulse("t5_press", 4'b1111, 1'b1);
    @(negedge clk);
    key_in = '1;
    wait_pulse("t5_release", 4'b1111, 1'b0);
    repeat (5) @(negedge clk);

    // 6. reset in the middle of a press confirmation
    key_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_level", int'(key_level), 0);
    check("t6_rst_press", int'(key_press), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_pulse("t6_press", 4'b0001, 1'b1);
    @(negedge clk);
    key_in[0] = 1'b1;
    repeat (12) @(negedge clk);

    // 7. random bouncing on all keys, occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          key_in[k] = 1'($urandom_range(0, 1));
          hold[k]   = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(3, 10);
        end else begin
          hold[k] = hold[k] - 1;
        end
      end
    end
    @(negedge clk);
    reset  = 1'b1;
    key_in = '1;
    repeat (20) @(negedge clk);
    check("end_level", int'(key_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
